seq_sub128: RTL and testbench

Multi-cycle 128-bit subtractor computing D = X − Y through a narrow CHUNK-bit borrow chain, least-significant chunk first, with one chunk per clock. It is the inverse-operation partner to the team's 128-bit ripple-carry adder. It sits behind a valid/ready operand interface and presents a held result until it is consumed. The goal is to trade latency for a short critical path: the per-cycle logic is a CHUNK-bit adder, not a 128-bit ripple.

---
 rtl/seq_sub128_if.sv | 26 ++
 rtl/seq_sub128.sv | 107 ++++++++++
 tb/tb_seq_sub128.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/seq_sub128_if.sv
// Operand/result bundle for seq_sub128: valid/ready operand side in, held result side out.
// Master drives operands and out_ready; slave (the subtractor) drives in_ready and the result.
interface seq_sub128_if #(
  parameter int WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bo;
  logic             V;
  logic             Z;

  modport master (
    output in_valid, X, Y, out_ready,
    input  in_ready, out_valid, D, Bo, V, Z
  );

  modport slave (
    input  in_valid, X, Y, out_ready,
    output in_ready, out_valid, D, Bo, V, Z
  );
endinterface

// File: rtl/seq_sub128.sv
// Multi-cycle D = X - Y, one CHUNK-bit borrow step per clock, LS chunk first; result after WIDTH/CHUNK cycles.
// Accepts only in IDLE; result is held in DONE until out_ready, then returns to IDLE.
module seq_sub128 #(
  parameter int WIDTH = 128,
  parameter int CHUNK = 32
) (
  input  logic        clk,
  input  logic        rst,
  seq_sub128_if.slave io
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  generate
    if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_chunk
      $error("seq_sub128: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, d_q, d_d;
  logic             c_q, c_d;
  logic [KW-1:0]    k_q, k_d;
  logic             bo_q, bo_d, v_q, v_d, z_q, z_d;
  logic [CHUNK-1:0] x_chunk, y_chunk;
  logic [CHUNK:0]   sum;

  always_comb begin
    x_chunk = x_q[k_q*CHUNK +: CHUNK];
    y_chunk = y_q[k_q*CHUNK +: CHUNK];
    // Subtraction as X + ~Y + 1; the carry register starts at 1 and carries the inverted borrow.
    sum     = {1'b0, x_chunk} + {1'b0, ~y_chunk} + {{CHUNK{1'b0}}, c_q};

    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    d_d     = d_q;
    c_d     = c_q;
    k_d     = k_q;
    bo_d    = bo_q;
    v_d     = v_q;
    z_d     = z_q;

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          x_d     = io.X;
          y_d     = io.Y;
          c_d     = 1'b1;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        d_d[k_q*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        c_d = sum[CHUNK];
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          bo_d    = ~sum[CHUNK];
          v_d     = (x_q[WIDTH-1] ^ y_q[WIDTH-1]) & (x_q[WIDTH-1] ^ d_d[WIDTH-1]);
          z_d     = (d_d == '0);
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      bo_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      d_q     <= d_d;
      c_q     <= c_d;
      k_q     <= k_d;
      bo_q    <= bo_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  // Handshake outputs depend on the state register only.
  assign io.in_ready  = (state_q == IDLE);
  assign io.out_valid = (state_q == DONE);
  assign io.D         = d_q;
  assign io.Bo        = bo_q;
  assign io.V         = v_q;
  assign io.Z         = z_q;
endmodule

// File: tb/tb_seq_sub128.sv
// Bench for seq_sub128: cycle model of the handshake plus a result scoreboard, directed cases then random traffic.
module tb_seq_sub128;
  localparam int W = 128;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0] d;
    logic         bo;
    logic         v;
    logic         z;
  } res_t;

  logic clk;
  logic rst;
  seq_sub128_if #(.WIDTH(W)) bus ();

  seq_sub128 #(.WIDTH(W), .CHUNK(32)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  int   m_state = 0;   // 0 idle, 1 run, 2 done
  int   m_cnt = 0;
  bit   just_rst = 0;
  bit   accepted = 0;
  int   consumed = 0;

  function automatic res_t ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    res_t r;
    logic [W:0] u;
    logic [W:0] s;
    u    = {1'b0, x} - {1'b0, y};
    s    = {x[W-1], x} - {y[W-1], y};
    r.d  = u[W-1:0];
    r.bo = u[W];
    r.v  = s[W] ^ s[W-1];
    r.z  = (u[W-1:0] == '0);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock edge: advance the reference model with the inputs held at the edge, then check outputs.
  task automatic cyc();
    res_t r;
    @(posedge clk);
    just_rst = 0;
    if (rst) begin
      m_state  = 0;
      m_cnt    = 0;
      just_rst = 1;
      exp_q.delete();
    end else begin
      case (m_state)
        0: if (bus.in_valid) begin
             exp_q.push_back(ref_sub(bus.X, bus.Y));
             m_state  = 1;
             m_cnt    = 0;
             accepted = 1;
           end
        1: begin
             m_cnt++;
             if (m_cnt == N) m_state = 2;
           end
        2: if (bus.out_ready) begin
             void'(exp_q.pop_front());
             m_state = 0;
             consumed++;
           end
        default: m_state = 0;
      endcase
    end
    #1;
    check("in_ready", W'(bus.in_ready), W'(m_state == 0));
    check("out_valid", W'(bus.out_valid), W'(m_state == 2));
    if (just_rst) begin
      check("rst_D", bus.D, '0);
      check("rst_flags", W'({bus.Bo, bus.V, bus.Z}), '0);
    end
    if (m_state == 2 && exp_q.size() > 0) begin
      r = exp_q[0];
      check("D", bus.D, r.d);
      check("Bo", W'(bus.Bo), W'(r.bo));
      check("V", W'(bus.V), W'(r.v));
      check("Z", W'(bus.Z), W'(r.z));
    end
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] exp_d, input logic exp_bo,
                       input logic exp_v, input logic exp_z, input int hold);
    int g;
    logic [W-1:0] d0;
    bus.X = x;
    bus.Y = y;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    accepted = 0;
    g = 0;
    while (!accepted && g < 20) begin cyc(); g++; end
    check("accept_timeout", W'(accepted), W'(1));
    bus.in_valid = 1'b0;
    bus.X = rnd128();
    bus.Y = rnd128();
    g = 0;
    while (!bus.out_valid && g < 20) begin cyc(); g++; end
    check("result_timeout", W'(bus.out_valid), W'(1));
    check("dir_D", bus.D, exp_d);
    check("dir_flags", W'({bus.Bo, bus.V, bus.Z}), W'({exp_bo, exp_v, exp_z}));
    d0 = bus.D;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      bus.X = rnd128();
      cyc();
      check("hold_D", bus.D, d0);
      check("hold_q", W'(exp_q.size()), W'(1));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a;
    int g;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.X = '0;
    bus.Y = '0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    do_op(W'(100), W'(58), W'(42), 1'b0, 1'b0, 1'b0, 0);
    a = W'(1) << 96;
    do_op(a, W'(1), {32'h0, {96{1'b1}}}, 1'b0, 1'b0, 1'b0, 0);
    do_op('0, W'(1), {W{1'b1}}, 1'b1, 1'b0, 1'b0, 0);
    a = {4{32'h1234_5678}};
    do_op(a, a, '0, 1'b0, 1'b0, 1'b1, 0);
    a = W'(1) << 127;
    do_op(a, W'(1), a - W'(1), 1'b0, 1'b1, 1'b0, 10);
    do_op(W'(7), W'(9), ~W'(1), 1'b1, 1'b0, 1'b0, 0);

    // Reset on the second RUN edge discards the operation.
    bus.X = W'(12345);
    bus.Y = W'(3);
    bus.in_valid = 1'b1;
    accepted = 0;
    g = 0;
    while (!accepted && g < 20) begin cyc(); g++; end
    bus.in_valid = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    do_op(W'(5), W'(7), ~W'(1), 1'b1, 1'b0, 1'b0, 0);

    // Random traffic with stalls on both sides.
    consumed = 0;
    g = 0;
    while (consumed < 1000 && g < 40000) begin
      bus.in_valid = ($urandom_range(0, 2) != 0);
      bus.X = rnd128();
      bus.Y = ($urandom_range(0, 7) == 0) ? bus.X : rnd128();
      bus.out_ready = ($urandom_range(0, 2) != 0);
      cyc();
      g++;
    end
    check("random_done", W'(consumed), W'(1000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
